// File: rtl/store_write_buffer_if.sv
// Store write buffer bus: store intake, load hazard probe, memory write port and status.
// Revision 1.0
`default_nettype none

interface store_write_buffer_if #(
    parameter int DATA_SIZE = 32
);
    logic                 st_valid;
    logic [DATA_SIZE-1:0] st_addr;
    logic [DATA_SIZE-1:0] st_data;
    logic [3:0]           st_web;
    logic [2:0]           st_core_type;
    logic                 st_ready;

    logic                 ld_check;
    logic [DATA_SIZE-1:0] ld_addr;
    logic                 ld_hazard;

    logic                 mem_req;
    logic [DATA_SIZE-1:0] mem_addr;
    logic [DATA_SIZE-1:0] mem_wdata;
    logic [3:0]           mem_web;
    logic [2:0]           mem_core_type;
    logic                 mem_ack;

    logic [2:0]           count;
    logic                 empty;

    // Buffer side
    modport slave (
        input  st_valid, st_addr, st_data, st_web, st_core_type,
        output st_ready,
        input  ld_check, ld_addr,
        output ld_hazard,
        output mem_req, mem_addr, mem_wdata, mem_web, mem_core_type,
        input  mem_ack,
        output count, empty
    );

    // Pipeline / memory side
    modport master (
        output st_valid, st_addr, st_data, st_web, st_core_type,
        input  st_ready,
        output ld_check, ld_addr,
        input  ld_hazard,
        input  mem_req, mem_addr, mem_wdata, mem_web, mem_core_type,
        output mem_ack,
        input  count, empty
    );
endinterface

`default_nettype wire

// File: rtl/store_write_buffer.sv
// store_write_buffer: in-order FIFO of pending stores draining to data memory,
// with word-granular load hazard detection. Revision 1.0
`default_nettype none

module store_write_buffer #(
    parameter int DATA_SIZE = 32,
    parameter int DEPTH     = 4
) (
    input  wire logic            clk,
    input  wire logic            rst,
    store_write_buffer_if.slave  bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [DATA_SIZE-1:0] r_addr  [DEPTH];
    logic [DATA_SIZE-1:0] r_data  [DEPTH];
    logic [3:0]           r_web   [DEPTH];
    logic [2:0]           r_ctype [DEPTH];
    logic [DEPTH-1:0]     r_valid;

    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;

    logic w_ready;
    logic w_push;
    logic w_pop;
    logic w_issue;
    logic w_hazard;

    assign w_ready = (r_count < CNT_W'(DEPTH));
    assign w_issue = (r_state == ISSUE);
    // All-ones web is a no-op store: handshake completes but nothing is queued
    assign w_push  = bus.st_valid & w_ready & (bus.st_web != 4'b1111);
    assign w_pop   = w_issue & bus.mem_ack;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_valid <= '0;
        end else begin
            if (w_push) begin
                r_valid[r_wptr] <= 1'b1;
                r_wptr <= (r_wptr == PTR_W'(DEPTH - 1)) ? '0 : r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_valid[r_rptr] <= 1'b0;
                r_rptr <= (r_rptr == PTR_W'(DEPTH - 1)) ? '0 : r_rptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage needs no reset; r_valid qualifies every use
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_wptr]  <= bus.st_addr;
            r_data[r_wptr]  <= bus.st_data;
            r_web[r_wptr]   <= bus.st_web;
            r_ctype[r_wptr] <= bus.st_core_type;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (r_count != '0) begin
                    w_state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (w_pop && (r_count == CNT_W'(1)) && !w_push) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // The head being popped this cycle still counts; a store arriving this cycle does not
    always_comb begin
        w_hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_valid[i] && ((r_addr[i] >> 2) == (bus.ld_addr >> 2))) begin
                w_hazard = 1'b1;
            end
        end
    end

    assign bus.st_ready      = w_ready;
    assign bus.ld_hazard     = bus.ld_check & w_hazard;
    assign bus.mem_req       = w_issue;
    assign bus.mem_addr      = w_issue ? r_addr[r_rptr]  : '0;
    assign bus.mem_wdata     = w_issue ? r_data[r_rptr]  : '0;
    assign bus.mem_web       = w_issue ? r_web[r_rptr]   : 4'b1111;
    assign bus.mem_core_type = w_issue ? r_ctype[r_rptr] : 3'b010;
    assign bus.count         = 3'(r_count);
    assign bus.empty         = (r_count == '0);

endmodule

`default_nettype wire
